voice_cfg_arbiter: RTL and testbench

- Shares the single AXI4-Lite master port that configures the my_voice register block (four 32-bit registers at byte offsets 0x0/0x4/0x8/0xC) between two requesters: requester 0 is the playback sequencer and requester 1 is the host-command path.
- Each requester issues simple register-index read/write commands. The block arbitrates between them round-robin and sequences the full AXI4-Lite handshake.
- It returns the read data and response status to the granted requester.

---
 rtl/voice_cfg_pkg.sv | 28 ++
 rtl/voice_rr_arb2.sv | 23 ++
 rtl/voice_cfg_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_voice_cfg_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_cfg_pkg.sv
// Shared types and constants for the my_voice configuration-port arbiter.
package voice_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [1:0]        idx;
    logic [DATA_W-1:0] wdata;
  } cfg_cmd_t;

endpackage

// File: rtl/voice_rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module voice_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant;

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (&req) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                 last_grant <= 1'b1;
    else if (take && gnt_valid) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/voice_cfg_arbiter.sv
// Shares one AXI4-Lite master between the playback sequencer (req0) and the
// host-command path (req1), one register transaction at a time.
module voice_cfg_arbiter
  import voice_cfg_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_BASE_ADDR  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,

  input  logic                    req0_valid,
  input  logic                    req0_we,
  input  logic [1:0]              req0_idx,
  input  logic [C_DATA_WIDTH-1:0] req0_wdata,
  output logic                    req0_done,
  output logic [C_DATA_WIDTH-1:0] req0_rdata,
  output logic                    req0_err,

  input  logic                    req1_valid,
  input  logic                    req1_we,
  input  logic [1:0]              req1_idx,
  input  logic [C_DATA_WIDTH-1:0] req1_wdata,
  output logic                    req1_done,
  output logic [C_DATA_WIDTH-1:0] req1_rdata,
  output logic                    req1_err,

  output logic                    busy,

  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [C_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_t state, state_n;
  logic   gnt_q, gnt_n;
  logic   busy_q, busy_n;
  logic   awvalid_q, awvalid_n, wvalid_q, wvalid_n;
  logic   aw_acc_q, aw_acc_n, w_acc_q, w_acc_n;
  logic   bready_q, bready_n, arvalid_q, arvalid_n, rready_q, rready_n;
  logic   err_q, err_n;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_n, araddr_q, araddr_n;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_n, rdata_q, rdata_n;

  logic     gnt_valid, gnt_idx, take;
  cfg_cmd_t cmd0, cmd1, sel;
  logic [C_ADDR_WIDTH-1:0] sel_addr;
  logic     aw_ok, w_ok;

  voice_rr_arb2 u_arb (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       ({req1_valid, req0_valid}),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cmd0     = '{we: req0_we, idx: req0_idx, wdata: req0_wdata};
  assign cmd1     = '{we: req1_we, idx: req1_idx, wdata: req1_wdata};
  assign sel      = gnt_idx ? cmd1 : cmd0;
  assign sel_addr = C_ADDR_WIDTH'(C_BASE_ADDR) + C_ADDR_WIDTH'({sel.idx, 2'b00});

  // A handshake counts as done if it was accepted earlier or is completing now.
  assign aw_ok = aw_acc_q | (awvalid_q & m_axi_awready);
  assign w_ok  = w_acc_q  | (wvalid_q  & m_axi_wready);

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    busy_n    = busy_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    aw_acc_n  = aw_acc_q;
    w_acc_n   = w_acc_q;
    bready_n  = bready_q;
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    err_n     = err_q;
    awaddr_n  = awaddr_q;
    araddr_n  = araddr_q;
    wdata_n   = wdata_q;
    rdata_n   = rdata_q;
    take      = 1'b0;
    unique case (state)
      IDLE: if (gnt_valid) begin
        take    = 1'b1;
        gnt_n   = gnt_idx;
        busy_n  = 1'b1;
        rdata_n = '0;
        err_n   = 1'b0;
        if (sel.we) begin
          awaddr_n  = sel_addr;
          wdata_n   = sel.wdata;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          aw_acc_n  = 1'b0;
          w_acc_n   = 1'b0;
          state_n   = WR_ADDR_DATA;
        end else begin
          araddr_n  = sel_addr;
          arvalid_n = 1'b1;
          state_n   = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (awvalid_q && m_axi_awready) begin awvalid_n = 1'b0; aw_acc_n = 1'b1; end
        if (wvalid_q && m_axi_wready)   begin wvalid_n  = 1'b0; w_acc_n  = 1'b1; end
        if (aw_ok && w_ok) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: if (m_axi_bvalid && bready_q) begin
        err_n    = (m_axi_bresp != RESP_OKAY);
        bready_n = 1'b0;
        state_n  = DONE;
      end
      RD_ADDR: if (arvalid_q && m_axi_arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (m_axi_rvalid && rready_q) begin
        rdata_n  = m_axi_rdata;
        err_n    = (m_axi_rresp != RESP_OKAY);
        rready_n = 1'b0;
        state_n  = DONE;
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state     <= IDLE;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_acc_q  <= 1'b0;
      w_acc_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      busy_q    <= busy_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      aw_acc_q  <= aw_acc_n;
      w_acc_q   <= w_acc_n;
      bready_q  <= bready_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      err_q     <= err_n;
      awaddr_q  <= awaddr_n;
      araddr_q  <= araddr_n;
      wdata_q   <= wdata_n;
      rdata_q   <= rdata_n;
    end
  end

  // Completion outputs are gated by DONE so the idle requester always sees zeros.
  assign req0_done  = (state == DONE) && !gnt_q;
  assign req1_done  = (state == DONE) &&  gnt_q;
  assign req0_rdata = req0_done ? rdata_q : '0;
  assign req1_rdata = req1_done ? rdata_q : '0;
  assign req0_err   = req0_done & err_q;
  assign req1_err   = req1_done & err_q;

  assign busy          = busy_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_voice_cfg_arbiter.sv
// Directed bench for voice_cfg_arbiter with a small AXI4-Lite slave model.
module tb_voice_cfg_arbiter;
  import voice_cfg_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [1:0]  req0_idx = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [1:0]  req1_idx = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_done, req0_err, req1_done, req1_err, busy;
  logic [31:0] req0_rdata, req1_rdata;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  voice_cfg_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_idx(req0_idx), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_idx(req1_idx), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Slave model: programmable AW/W stalls, withheld B, programmable RRESP.
  logic [31:0] mem [4];
  int          aw_wait = 0, w_wait = 0;
  int          aw_cnt = 0, w_cnt = 0;
  bit          b_hold = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        got_aw = 1'b0, got_w = 1'b0;
  logic [3:0]  aw_addr_s = '0, last_awaddr = '0, last_araddr = '0, last_wstrb = '0;
  logic [31:0] w_data_s = '0, last_wdata = '0;
  int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  int          d0_cnt = 0, d1_cnt = 0;
  logic        dual_done = 1'b0;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;

  wire         aw_hs = m_axi_awvalid && m_axi_awready;
  wire         w_hs  = m_axi_wvalid && m_axi_wready;
  wire         ar_hs = m_axi_arvalid && m_axi_arready;
  wire [3:0]   wa    = aw_hs ? m_axi_awaddr : aw_addr_s;
  wire [31:0]  wd    = w_hs ? m_axi_wdata : w_data_s;
  wire [1:0]   wi    = wa[3:2];
  wire [1:0]   ri    = m_axi_araddr[3:2];

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_bvalid  = s_bvalid;
  assign m_axi_bresp   = 2'b00;
  assign m_axi_rvalid  = s_rvalid;
  assign m_axi_rdata   = s_rdata;
  assign m_axi_rresp   = s_rresp;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin
        got_aw <= 1'b1; aw_addr_s <= m_axi_awaddr; last_awaddr <= m_axi_awaddr;
        aw_hs_n <= aw_hs_n + 1;
      end
      if (w_hs) begin
        got_w <= 1'b1; w_data_s <= m_axi_wdata; last_wdata <= m_axi_wdata;
        last_wstrb <= m_axi_wstrb; w_hs_n <= w_hs_n + 1;
      end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        mem[wi] <= wd; got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= !b_hold;
      end
      if (s_bvalid && m_axi_bready) begin s_bvalid <= 1'b0; b_hs_n <= b_hs_n + 1; end
      if (ar_hs) begin
        s_rvalid <= 1'b1; s_rdata <= mem[ri]; s_rresp <= rresp_cfg; last_araddr <= m_axi_araddr;
      end
      if (s_rvalid && m_axi_rready) s_rvalid <= 1'b0;
    end
  end

  always @(negedge ACLK) begin
    if (req0_done) d0_cnt <= d0_cnt + 1;
    if (req1_done) d1_cnt <= d1_cnt + 1;
    if (req0_done && req1_done) dual_done <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic we, input logic [1:0] idx,
                       input logic [31:0] wd);
    if (n == 0) begin req0_valid = v; req0_we = we; req0_idx = idx; req0_wdata = wd; end
    else        begin req1_valid = v; req1_we = we; req1_idx = idx; req1_wdata = wd; end
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  // Issue one command from requester n starting in IDLE; lat counts the
  // sampling cycle through the done cycle inclusive.
  task automatic do_req(input int n, input logic we, input logic [1:0] idx, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got = 1'b0;
    lat = 1; rd = '0; er = 1'b0;
    drive(n, 1'b1, we, idx, wd);
    while (!got && lat < 60) begin
      @(negedge ACLK);
      lat++;
      if (n == 0 ? req0_done : req1_done) begin
        got = 1'b1;
        rd  = (n == 0) ? req0_rdata : req1_rdata;
        er  = (n == 0) ? req0_err : req1_err;
      end
    end
    drive(n, 1'b0, 1'b0, 2'd0, 32'd0);
    check($sformatf("done_seen_req%0d", n), {31'b0, got}, 32'd1);
    @(negedge ACLK);
  endtask

  // Raise both requesters together and record completion order.
  task automatic run_pair(input logic we0, input logic [1:0] idx0, input logic [31:0] wd0,
                          input logic we1, input logic [1:0] idx1, input logic [31:0] wd1,
                          output int first, output int second, output logic [31:0] rd1);
    int k = 0, cyc = 0;
    first = -1; second = -1; rd1 = '0;
    drive(0, 1'b1, we0, idx0, wd0);
    drive(1, 1'b1, we1, idx1, wd1);
    while (k < 2 && cyc < 80) begin
      @(negedge ACLK);
      cyc++;
      if (req0_done) begin
        if (k == 0) first = 0; else second = 0;
        k++; drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
      end
      if (req1_done) begin
        if (k == 0) first = 1; else second = 1;
        k++; rd1 = req1_rdata; drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
      end
    end
    drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge ACLK);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, g_first, g_second;
    int          ord[4];
    int          k, cyc, aw0, w0, b0, d0;
    bit          hit;

    // Reset state
    apply_reset();
    check("rst_ctrl", {22'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                       m_axi_rready, busy, req0_done, req1_done, req0_err, req1_err}, 32'd0);
    check("rst_awaddr", {28'b0, m_axi_awaddr}, 32'd0);
    check("rst_araddr", {28'b0, m_axi_araddr}, 32'd0);
    check("rst_wdata", m_axi_wdata, 32'd0);
    check("rst_rdata", req0_rdata | req1_rdata, 32'd0);

    // 1: single write
    do_req(0, 1'b1, REG_CTRL, 32'h0000_0001, rd, er, lat);
    check("t1_awaddr", {28'b0, last_awaddr}, 32'h0);
    check("t1_wdata", last_wdata, 32'h1);
    check("t1_wstrb", {28'b0, last_wstrb}, 32'hF);
    check("t1_latency", lat, 32'd4);
    check("t1_err", {31'b0, er}, 32'd0);
    check("t1_rdata_wr", rd, 32'd0);
    check("t1_busy_after", {31'b0, busy}, 32'd0);

    // 2: simultaneous requests from reset, then both held continuously
    apply_reset();
    run_pair(1'b1, REG_STAT, 32'hA5A5_A5A5, 1'b0, REG_STAT, 32'd0, g_first, g_second, rd);
    check("t2_first", g_first, 32'd0);
    check("t2_second", g_second, 32'd1);
    check("t2_rdata1", rd, 32'hA5A5_A5A5);
    drive(0, 1'b1, 1'b0, REG_STAT, 32'd0);
    drive(1, 1'b1, 1'b0, REG_STAT, 32'd0);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      if (req0_done) begin ord[k] = 0; k++; end
      if (req1_done && k < 4) begin ord[k] = 1; k++; end
    end
    drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge ACLK);
    check("t2_held_count", k, 32'd4);
    check("t2_held_order", {28'b0, ord[0][0], ord[1][0], ord[2][0], ord[3][0]}, 32'b0101);
    check("t2_no_dual_done", {31'b0, dual_done}, 32'd0);

    // 3: W accepted 3 cycles before AW
    aw_wait = 3;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; d0 = d0_cnt;
    do_req(0, 1'b1, REG_DATA, 32'h0000_0033, rd, er, lat);
    repeat (3) @(negedge ACLK);
    aw_wait = 0;
    check("t3_latency", lat, 32'd7);
    check("t3_aw_once", aw_hs_n - aw0, 32'd1);
    check("t3_w_once", w_hs_n - w0, 32'd1);
    check("t3_b_once", b_hs_n - b0, 32'd1);
    check("t3_done_once", d0_cnt - d0, 32'd1);
    check("t3_mem", mem[2], 32'h33);

    // 4: write all registers then read back via requester 1
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, 2'(i), 32'(i + 1), rd, er, lat);
      check($sformatf("t4_awaddr%0d", i), {28'b0, last_awaddr}, 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 2'(i), 32'd0, rd, er, lat);
      check($sformatf("t4_araddr%0d", i), {28'b0, last_araddr}, 32'(4 * i));
      check($sformatf("t4_rdata%0d", i), rd, 32'(i + 1));
      if (i == 0) check("t4_rd_latency", lat, 32'd4);
    end

    // 5: SLVERR on read, then a clean read
    rresp_cfg = 2'b10;
    do_req(1, 1'b0, REG_CTRL, 32'd0, rd, er, lat);
    check("t5_err", {31'b0, er}, 32'd1);
    rresp_cfg = 2'b00;
    do_req(1, 1'b0, REG_CTRL, 32'd0, rd, er, lat);
    check("t5_err_clear", {31'b0, er}, 32'd0);

    // 6: reset while waiting on a withheld B response
    b_hold = 1'b1;
    drive(0, 1'b1, 1'b1, REG_CFG, 32'h0000_0077);
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 20) begin
      @(negedge ACLK);
      cyc++;
      hit = m_axi_bready;
    end
    check("t6_reached_wr_resp", {31'b0, hit}, 32'd1);
    ARESETN = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
    @(negedge ACLK);
    check("t6_rst_ctrl", {26'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, busy}, 32'd0);
    check("t6_rst_done", {30'b0, req0_done, req1_done}, 32'd0);
    ARESETN = 1'b1;
    b_hold  = 1'b0;
    @(negedge ACLK);
    run_pair(1'b0, REG_CTRL, 32'd0, 1'b0, REG_STAT, 32'd0, g_first, g_second, rd);
    check("t6_first_after_rst", g_first, 32'd0);
    check("t6_second_after_rst", g_second, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
